// File: rtl/pokey_serin_rx.sv
// POKEY serial-input deserialiser: 8N1 frames on a 16x oversample strobe,
// producing SERIN, the serial-input-done request and the SKSTAT error bits.
module pokey_serin_rx #(
  parameter int unsigned OVS   = 16,
  parameter int unsigned DBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enp,
  input  logic             tick,
  input  logic             sid,
  input  logic             irq_ack,
  input  logic             skres,
  output logic [DBITS-1:0] serin,
  output logic             rx_done,
  output logic             irq_pend,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic             sid_sync
);

  localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned BW = $clog2(DBITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q;
  logic [TW-1:0]    tcnt_q;
  logic [BW-1:0]    bcnt_q;
  logic [DBITS-1:0] shift_q, serin_q;
  logic             rx_done_q, irq_q, ferr_q, ovr_q;

  logic             step, tc_half, tc_full, complete;
  logic [DBITS-1:0] shift_d;

  assign step     = enp & tick;
  assign tc_half  = (tcnt_q == TW'(OVS/2 - 1));
  assign tc_full  = (tcnt_q == TW'(OVS - 1));
  assign complete = step && (state_q == STOP) && tc_full;
  // Right shift so the first (LSB) data bit lands in bit 0 after DBITS samples.
  assign shift_d  = {sync2_q, shift_q[DBITS-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      serin_q   <= '0;
      rx_done_q <= 1'b0;
      irq_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (enp) begin
        sync1_q <= sid;
        sync2_q <= sync1_q;
      end

      rx_done_q <= complete;
      if (complete) serin_q <= shift_q;

      // Set has priority over the clear strobes, which ignore enp.
      if (complete)      irq_q <= 1'b1;
      else if (irq_ack)  irq_q <= 1'b0;
      if (complete && !sync2_q) ferr_q <= 1'b1;
      else if (skres)           ferr_q <= 1'b0;
      if (complete && irq_q)    ovr_q  <= 1'b1;
      else if (skres)           ovr_q  <= 1'b0;

      if (step) begin
        case (state_q)
          IDLE: begin
            if (!sync2_q) begin
              state_q <= START;
              tcnt_q  <= '0;
            end
          end
          START: begin
            if (tc_half) begin
              tcnt_q  <= '0;
              bcnt_q  <= '0;
              state_q <= sync2_q ? IDLE : DATA;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          DATA: begin
            if (tc_full) begin
              tcnt_q  <= '0;
              shift_q <= shift_d;
              bcnt_q  <= bcnt_q + 1'b1;
              if (bcnt_q == BW'(DBITS - 1)) state_q <= STOP;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          STOP: begin
            if (tc_full) begin
              tcnt_q  <= '0;
              state_q <= IDLE;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign serin     = serin_q;
  assign rx_done   = rx_done_q;
  assign irq_pend  = irq_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
  assign sid_sync  = sync2_q;

endmodule

// File: tb/tb_pokey_serin_rx.sv
// Directed bench for pokey_serin_rx: frames driven bit-by-bit in steps,
// outputs sampled on the falling clock edge against hand-computed values.
module tb_pokey_serin_rx;
  localparam int unsigned OVS   = 16;
  localparam int unsigned DBITS = 8;

  logic             clk = 1'b0;
  logic             reset, enp, tick, sid, irq_ack, skres;
  logic [DBITS-1:0] serin;
  logic             rx_done, irq_pend, frame_err, overrun, busy, sid_sync;

  int checks = 0;
  int errors = 0;
  int encyc = 0, done_cnt = 0, done_en = 0, busy_cnt = 0;
  logic done_busy = 1'b0, done_prev_busy = 1'b0, busy_prev = 1'b0;
  int kclk = 0, ack_at = 0, stepcnt = 0, start_en = 0, ph = 0;
  bit duty3 = 1'b0;
  int d0, b0;

  pokey_serin_rx #(.OVS(OVS), .DBITS(DBITS)) dut (
    .clk(clk), .reset(reset), .enp(enp), .tick(tick), .sid(sid),
    .irq_ack(irq_ack), .skres(skres), .serin(serin), .rx_done(rx_done),
    .irq_pend(irq_pend), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .sid_sync(sid_sync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (enp) encyc++;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_en        = encyc;
      done_busy      = busy;
      done_prev_busy = busy_prev;
    end
    if (busy) busy_cnt++;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: choose enp for the coming rising edge, then wait for the falling edge.
  task automatic clk1();
    kclk++;
    if (ack_at != 0) irq_ack = (kclk == ack_at);
    enp = duty3 ? (ph == 0) : 1'b1;
    ph  = (ph == 2) ? 0 : ph + 1;
    if (enp && tick) stepcnt++;
    @(negedge clk);
    if (ack_at != 0) irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) clk1();
  endtask

  task automatic hold(input int n);
    int s0;
    s0 = stepcnt;
    while (stepcnt - s0 < n) clk1();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input int ack_clk);
    kclk     = 0;
    ack_at   = ack_clk;
    start_en = encyc;
    for (int b = 0; b < 10; b++) begin
      sid = (b == 0) ? 1'b0 : (b == 9) ? stopb : d[b-1];
      hold(OVS);
    end
    sid    = 1'b1;
    ack_at = 0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; clk1(); irq_ack = 1'b0;
  endtask

  task automatic pulse_skres();
    skres = 1'b1; clk1(); skres = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enp = 1'b1; tick = 1'b1; sid = 1'b1; irq_ack = 1'b0; skres = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serin", 32'(serin), 32'h0);
    chk("rst_done",  32'(rx_done), 32'h0);
    chk("rst_irq",   32'(irq_pend), 32'h0);
    chk("rst_ferr",  32'(frame_err), 32'h0);
    chk("rst_ovr",   32'(overrun), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_sync",  32'(sid_sync), 32'h1);
    reset = 1'b0;
    idle(5);

    // Clean frame 0xA5
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 0);
    idle(20);
    chk("a5_pulses",  32'(done_cnt - d0), 32'd1);
    chk("a5_serin",   32'(serin), 32'hA5);
    chk("a5_irq",     32'(irq_pend), 32'h1);
    chk("a5_ferr",    32'(frame_err), 32'h0);
    chk("a5_ovr",     32'(overrun), 32'h0);
    chk("a5_busy_at_done",  32'(done_busy), 32'h0);
    chk("a5_busy_before",   32'(done_prev_busy), 32'h1);
    chk("a5_latency", 32'(done_en - start_en), 32'd155);
    pulse_ack();
    chk("ack_clears_irq", 32'(irq_pend), 32'h0);

    // 4-clock low glitch: false start after 8 steps in START
    b0 = busy_cnt; d0 = done_cnt;
    sid = 1'b0; idle(4); sid = 1'b1;
    idle(20);
    chk("gl_busy_len", 32'(busy_cnt - b0), 32'd8);
    chk("gl_pulses",   32'(done_cnt - d0), 32'd0);
    chk("gl_serin",    32'(serin), 32'hA5);
    chk("gl_irq",      32'(irq_pend), 32'h0);
    chk("gl_ferr",     32'(frame_err), 32'h0);
    chk("gl_ovr",      32'(overrun), 32'h0);

    // Framing error on 0x3C
    send_frame(8'h3C, 1'b0, 0);
    idle(30);
    chk("fe_serin", 32'(serin), 32'h3C);
    chk("fe_ferr",  32'(frame_err), 32'h1);
    chk("fe_irq",   32'(irq_pend), 32'h1);
    chk("fe_ovr",   32'(overrun), 32'h0);
    pulse_skres();
    chk("fe_skres_ferr",  32'(frame_err), 32'h0);
    chk("fe_skres_serin", 32'(serin), 32'h3C);
    pulse_ack();

    // Overrun, with irq_ack colliding with the second completion
    send_frame(8'h11, 1'b1, 0);
    idle(20);
    chk("ov1_serin", 32'(serin), 32'h11);
    chk("ov1_ovr",   32'(overrun), 32'h0);
    send_frame(8'h22, 1'b1, 155);
    idle(20);
    chk("ov2_serin", 32'(serin), 32'h22);
    chk("ov2_ovr",   32'(overrun), 32'h1);
    chk("ov2_irq_set_wins", 32'(irq_pend), 32'h1);
    chk("ov2_ferr",  32'(frame_err), 32'h0);
    pulse_skres();
    chk("ov_skres_ovr", 32'(overrun), 32'h0);

    // Reset in the middle of data bit 4 of 0xFF
    kclk = 0;
    sid = 1'b0; hold(OVS);
    sid = 1'b1; hold(OVS * 4 + 4);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("mr_serin", 32'(serin), 32'h0);
    chk("mr_done",  32'(rx_done), 32'h0);
    chk("mr_irq",   32'(irq_pend), 32'h0);
    chk("mr_ferr",  32'(frame_err), 32'h0);
    chk("mr_ovr",   32'(overrun), 32'h0);
    chk("mr_busy",  32'(busy), 32'h0);
    chk("mr_sync",  32'(sid_sync), 32'h1);
    clk1();
    reset = 1'b0;
    idle(20);
    d0 = done_cnt;
    send_frame(8'h81, 1'b1, 0);
    idle(20);
    chk("r81_pulses", 32'(done_cnt - d0), 32'd1);
    chk("r81_serin",  32'(serin), 32'h81);
    chk("r81_ferr",   32'(frame_err), 32'h0);
    chk("r81_ovr",    32'(overrun), 32'h0);
    pulse_ack();

    // enp at 1/3 duty: timing follows enp-qualified clocks only
    duty3 = 1'b1; ph = 0;
    idle(9);
    d0 = done_cnt;
    send_frame(8'h5A, 1'b1, 0);
    idle(90);
    chk("d3_pulses",  32'(done_cnt - d0), 32'd1);
    chk("d3_serin",   32'(serin), 32'h5A);
    chk("d3_latency", 32'(done_en - start_en), 32'd155);
    chk("d3_ferr",    32'(frame_err), 32'h0);
    chk("d3_ovr",     32'(overrun), 32'h0);
    duty3 = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
